// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU pipeline definitions: forward-select encodings used by the hazard
// unit and the datapath operand muxes.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_e;

    // Memory-stage result is younger than writeback, so it wins when both hit.
    function automatic fwd_sel_e fwd_sel(input logic hit_m, input logic hit_w);
        if (hit_m)
            return FWD_M;
        else if (hit_w)
            return FWD_W;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md.sv
// Multiply/divide busy window: loads MD_LAT on an advancing issue and counts
// down to zero; busy is purely a function of the registered count.
module md_busy_timer #(
    parameter int unsigned MD_LAT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    output logic busy
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (start)
            count <= 4'(MD_LAT);
        else if (count != '0)
            count <= count - 4'd1;
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding selects, load-use / branch / mul-div
// stalls, data-memory freeze, and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] rs_D,
    input  logic [REG_W-1:0] rt_D,
    input  logic             branch_D,
    input  logic             md_use_D,
    input  logic [REG_W-1:0] rs_E,
    input  logic [REG_W-1:0] rt_E,
    input  logic [REG_W-1:0] reg_id_E,
    input  logic             reg_write_E,
    input  logic             mem_to_reg_E,
    input  logic             md_start_E,
    input  logic [REG_W-1:0] reg_id_M,
    input  logic             reg_write_M,
    input  logic             mem_to_reg_M,
    input  logic             mem_access_M,
    input  logic             mem_ready_M,
    input  logic [REG_W-1:0] reg_id_W,
    input  logic             reg_write_W,
    output logic             pc_enab,
    output logic             enab_FD,
    output logic             enab_EMW,
    output logic             flush_DE,
    output logic             forwardA_D,
    output logic             forwardB_D,
    output logic [1:0]       forwardA_E,
    output logic [1:0]       forwardB_E,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic     m_valid, w_valid, e_valid;
    logic     e_hits_d, m_hits_d;
    logic     lw_stall, br_stall, md_stall, mem_freeze, any_stall;
    fwd_sel_e fwd_a_e, fwd_b_e;

    assign m_valid = reg_write_M && (reg_id_M != '0);
    assign w_valid = reg_write_W && (reg_id_W != '0);
    assign e_valid = reg_id_E != '0;

    assign fwd_a_e    = fwd_sel(m_valid && (rs_E == reg_id_M), w_valid && (rs_E == reg_id_W));
    assign fwd_b_e    = fwd_sel(m_valid && (rt_E == reg_id_M), w_valid && (rt_E == reg_id_W));
    assign forwardA_E = fwd_a_e;
    assign forwardB_E = fwd_b_e;

    assign forwardA_D = m_valid && (rs_D == reg_id_M);
    assign forwardB_D = m_valid && (rt_D == reg_id_M);

    assign e_hits_d = e_valid && ((reg_id_E == rs_D) || (reg_id_E == rt_D));
    assign m_hits_d = (reg_id_M != '0) && ((reg_id_M == rs_D) || (reg_id_M == rt_D));

    assign lw_stall   = mem_to_reg_E && reg_write_E && e_hits_d;
    assign br_stall   = branch_D && ((reg_write_E && e_hits_d) || (mem_to_reg_M && m_hits_d));
    assign md_stall   = md_busy && md_use_D;
    assign mem_freeze = mem_access_M && !mem_ready_M;
    assign any_stall  = lw_stall || br_stall || md_stall;

    // Freeze holds every stage in place, so decode must not be bubbled either.
    always_comb begin
        pc_enab  = 1'b1;
        enab_FD  = 1'b1;
        enab_EMW = 1'b1;
        flush_DE = 1'b0;
        if (mem_freeze) begin
            pc_enab  = 1'b0;
            enab_FD  = 1'b0;
            enab_EMW = 1'b0;
        end else if (any_stall) begin
            pc_enab  = 1'b0;
            enab_FD  = 1'b0;
            flush_DE = 1'b1;
        end
    end

    md_busy_timer #(
        .MD_LAT(MD_LAT)
    ) u_md_busy_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (md_start_E && enab_EMW),
        .busy   (md_busy)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if ((mem_freeze || any_stall) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed checks of hazard_ctrl: forwarding, stalls, freeze, mul/div window,
// counter saturation (narrow instance) and asynchronous reset.
module tb_hazard_ctrl;

    localparam int unsigned REG_W = 5;

    logic             clk;
    logic             reset_n;
    logic [REG_W-1:0] rs_D, rt_D, rs_E, rt_E, reg_id_E, reg_id_M, reg_id_W;
    logic             branch_D, md_use_D, reg_write_E, mem_to_reg_E, md_start_E;
    logic             reg_write_M, mem_to_reg_M, mem_access_M, mem_ready_M, reg_write_W;

    logic        pc_enab, enab_FD, enab_EMW, flush_DE, forwardA_D, forwardB_D, md_busy;
    logic [1:0]  forwardA_E, forwardB_E;
    logic [15:0] stall_cnt;

    logic        pc_enab2, enab_FD2, enab_EMW2, flush_DE2, forwardA_D2, forwardB_D2, md_busy2;
    logic [1:0]  forwardA_E2, forwardB_E2;
    logic [1:0]  stall_cnt2;

    int n_cmp;
    int n_err;

    hazard_ctrl #(.REG_W(REG_W), .MD_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs_D(rs_D), .rt_D(rt_D), .branch_D(branch_D), .md_use_D(md_use_D),
        .rs_E(rs_E), .rt_E(rt_E), .reg_id_E(reg_id_E), .reg_write_E(reg_write_E),
        .mem_to_reg_E(mem_to_reg_E), .md_start_E(md_start_E),
        .reg_id_M(reg_id_M), .reg_write_M(reg_write_M), .mem_to_reg_M(mem_to_reg_M),
        .mem_access_M(mem_access_M), .mem_ready_M(mem_ready_M),
        .reg_id_W(reg_id_W), .reg_write_W(reg_write_W),
        .pc_enab(pc_enab), .enab_FD(enab_FD), .enab_EMW(enab_EMW), .flush_DE(flush_DE),
        .forwardA_D(forwardA_D), .forwardB_D(forwardB_D),
        .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.REG_W(REG_W), .MD_LAT(4), .CNT_W(2)) dut_narrow (
        .clk(clk), .reset_n(reset_n),
        .rs_D(rs_D), .rt_D(rt_D), .branch_D(branch_D), .md_use_D(md_use_D),
        .rs_E(rs_E), .rt_E(rt_E), .reg_id_E(reg_id_E), .reg_write_E(reg_write_E),
        .mem_to_reg_E(mem_to_reg_E), .md_start_E(md_start_E),
        .reg_id_M(reg_id_M), .reg_write_M(reg_write_M), .mem_to_reg_M(mem_to_reg_M),
        .mem_access_M(mem_access_M), .mem_ready_M(mem_ready_M),
        .reg_id_W(reg_id_W), .reg_write_W(reg_write_W),
        .pc_enab(pc_enab2), .enab_FD(enab_FD2), .enab_EMW(enab_EMW2), .flush_DE(flush_DE2),
        .forwardA_D(forwardA_D2), .forwardB_D(forwardB_D2),
        .forwardA_E(forwardA_E2), .forwardB_E(forwardB_E2),
        .md_busy(md_busy2), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_enab, enab_FD, enab_EMW, flush_DE}
    logic [3:0] enables;
    assign enables = {pc_enab, enab_FD, enab_EMW, flush_DE};

    task automatic clear_inputs();
        rs_D = '0; rt_D = '0; branch_D = 1'b0; md_use_D = 1'b0;
        rs_E = '0; rt_E = '0; reg_id_E = '0; reg_write_E = 1'b0;
        mem_to_reg_E = 1'b0; md_start_E = 1'b0;
        reg_id_M = '0; reg_write_M = 1'b0; mem_to_reg_M = 1'b0;
        mem_access_M = 1'b0; mem_ready_M = 1'b0;
        reg_id_W = '0; reg_write_W = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (md_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_md_busy got=%b exp=0", md_busy);
        end
        n_cmp++;
        if (stall_cnt !== 16'd0) begin
            n_err++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt);
        end
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (enables !== 4'b1110) begin
            n_err++; $display("FAIL reset_enables got=%b exp=1110", enables);
        end
    endtask

    task automatic test_forward_e();
        do_reset();
        rs_E = 5'd3; reg_id_M = 5'd3; reg_write_M = 1'b1; reg_id_W = 5'd3; reg_write_W = 1'b1;
        #1;
        n_cmp++;
        if (forwardA_E !== 2'b10) begin
            n_err++; $display("FAIL fwdA_E_m_priority got=%b exp=10", forwardA_E);
        end
        rs_E = 5'd0;
        #1;
        n_cmp++;
        if (forwardA_E !== 2'b00) begin
            n_err++; $display("FAIL fwdA_E_r0 got=%b exp=00", forwardA_E);
        end
        rs_E = 5'd3; reg_write_M = 1'b0;
        #1;
        n_cmp++;
        if (forwardA_E !== 2'b01) begin
            n_err++; $display("FAIL fwdA_E_w got=%b exp=01", forwardA_E);
        end
        rt_E = 5'd3; reg_id_M = 5'd4; reg_write_M = 1'b1;
        #1;
        n_cmp++;
        if (forwardB_E !== 2'b01) begin
            n_err++; $display("FAIL fwdB_E_w got=%b exp=01", forwardB_E);
        end
        rt_E = 5'd4;
        #1;
        n_cmp++;
        if (forwardB_E !== 2'b10) begin
            n_err++; $display("FAIL fwdB_E_m got=%b exp=10", forwardB_E);
        end
        reg_write_M = 1'b0;
        #1;
        n_cmp++;
        if (forwardB_E !== 2'b00) begin
            n_err++; $display("FAIL fwdB_E_none got=%b exp=00", forwardB_E);
        end
    endtask

    task automatic test_forward_d();
        do_reset();
        rs_D = 5'd6; rt_D = 5'd2; reg_id_M = 5'd6; reg_write_M = 1'b1;
        #1;
        n_cmp++;
        if ({forwardA_D, forwardB_D} !== 2'b10) begin
            n_err++; $display("FAIL fwd_D_a got=%b exp=10", {forwardA_D, forwardB_D});
        end
        rt_D = 5'd6;
        #1;
        n_cmp++;
        if ({forwardA_D, forwardB_D} !== 2'b11) begin
            n_err++; $display("FAIL fwd_D_ab got=%b exp=11", {forwardA_D, forwardB_D});
        end
        reg_write_M = 1'b0;
        #1;
        n_cmp++;
        if ({forwardA_D, forwardB_D} !== 2'b00) begin
            n_err++; $display("FAIL fwd_D_nowrite got=%b exp=00", {forwardA_D, forwardB_D});
        end
    endtask

    task automatic test_lw_stall();
        do_reset();
        reg_id_E = 5'd0; mem_to_reg_E = 1'b1; reg_write_E = 1'b1;
        #1;
        n_cmp++;
        if (enables !== 4'b1110) begin
            n_err++; $display("FAIL lw_r0_no_stall got=%b exp=1110", enables);
        end
        reg_id_E = 5'd5; rt_D = 5'd5;
        #1;
        n_cmp++;
        if (enables !== 4'b0011) begin
            n_err++; $display("FAIL lw_stall_enables got=%b exp=0011", enables);
        end
        tick();
        n_cmp++;
        if (stall_cnt !== 16'd1) begin
            n_err++; $display("FAIL lw_stall_cnt got=%0d exp=1", stall_cnt);
        end
        clear_inputs();
        #1;
        n_cmp++;
        if (enables !== 4'b1110) begin
            n_err++; $display("FAIL lw_release got=%b exp=1110", enables);
        end
        tick();
        n_cmp++;
        if (stall_cnt !== 16'd1) begin
            n_err++; $display("FAIL lw_cnt_hold got=%0d exp=1", stall_cnt);
        end
    endtask

    task automatic test_br_stall();
        do_reset();
        branch_D = 1'b1; reg_write_E = 1'b1; reg_id_E = 5'd4; rs_D = 5'd4;
        #1;
        n_cmp++;
        if (enables !== 4'b0011) begin
            n_err++; $display("FAIL br_stall_E got=%b exp=0011", enables);
        end
        reg_write_E = 1'b0; rs_D = 5'd0; mem_to_reg_M = 1'b1; reg_id_M = 5'd9; rt_D = 5'd9;
        #1;
        n_cmp++;
        if (enables !== 4'b0011) begin
            n_err++; $display("FAIL br_stall_M got=%b exp=0011", enables);
        end
        branch_D = 1'b0;
        #1;
        n_cmp++;
        if (enables !== 4'b1110) begin
            n_err++; $display("FAIL br_no_branch got=%b exp=1110", enables);
        end
    endtask

    task automatic test_md_window();
        do_reset();
        md_start_E = 1'b1;
        tick();
        md_start_E = 1'b0; md_use_D = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if ({md_busy, enables} !== 5'b1_0011) begin
                n_err++; $display("FAIL md_window_%0d got=%b exp=10011", i, {md_busy, enables});
            end
            tick();
        end
        n_cmp++;
        if ({md_busy, enables} !== 5'b0_1110) begin
            n_err++; $display("FAIL md_window_end got=%b exp=01110", {md_busy, enables});
        end
        n_cmp++;
        if (stall_cnt !== 16'd4) begin
            n_err++; $display("FAIL md_stall_cnt got=%0d exp=4", stall_cnt);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        md_start_E = 1'b1;
        tick();
        mem_access_M = 1'b1; mem_ready_M = 1'b0;
        mem_to_reg_E = 1'b1; reg_write_E = 1'b1; reg_id_E = 5'd5; rs_D = 5'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ({md_busy, enables} !== 5'b1_0000) begin
                n_err++; $display("FAIL freeze_%0d got=%b exp=10000", i, {md_busy, enables});
            end
            tick();
        end
        n_cmp++;
        if (stall_cnt !== 16'd3) begin
            n_err++; $display("FAIL freeze_stall_cnt got=%0d exp=3", stall_cnt);
        end
        clear_inputs();
        #1;
        n_cmp++;
        if (md_busy !== 1'b1) begin
            n_err++; $display("FAIL freeze_md_last got=%b exp=1", md_busy);
        end
        tick();
        n_cmp++;
        if ({md_busy, stall_cnt} !== {1'b0, 16'd3}) begin
            n_err++; $display("FAIL freeze_md_done busy=%b cnt=%0d exp busy=0 cnt=3", md_busy, stall_cnt);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_seq [6];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        do_reset();
        mem_to_reg_E = 1'b1; reg_write_E = 1'b1; reg_id_E = 5'd7; rt_D = 5'd7;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (stall_cnt2 !== exp_seq[i]) begin
                n_err++; $display("FAIL saturate_%0d got=%0d exp=%0d", i, stall_cnt2, exp_seq[i]);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        mem_to_reg_E = 1'b1; reg_write_E = 1'b1; reg_id_E = 5'd5; rs_D = 5'd5;
        md_start_E = 1'b1;
        tick();
        md_start_E = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({md_busy, stall_cnt, stall_cnt2} !== {1'b0, 16'd0, 2'd0}) begin
            n_err++; $display("FAIL async_reset busy=%b cnt=%0d cnt2=%0d exp 0/0/0", md_busy, stall_cnt, stall_cnt2);
        end
        n_cmp++;
        if (enables !== 4'b0011) begin
            n_err++; $display("FAIL reset_comb_enables got=%b exp=0011", enables);
        end
        reset_n = 1'b1;
        clear_inputs();
        tick();
        n_cmp++;
        if ({md_busy, stall_cnt} !== {1'b0, 16'd0}) begin
            n_err++; $display("FAIL post_reset busy=%b cnt=%0d exp 0/0", md_busy, stall_cnt);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear_inputs();
        reset_n = 1'b0;
        #2;
        test_reset();
        tick();
        test_forward_e();
        test_forward_d();
        test_lw_stall();
        test_br_stall();
        test_md_window();
        test_freeze();
        test_saturate();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
